sort_unit_vrdy: RTL

SORT_UNIT_VRDY -- requirements
Module: sort_unit_vrdy

---
 rtl/sort_unit_vrdy.sv | 100 ++++++++++
 1 files changed

// File: rtl/sort_unit_vrdy.sv
// Four-element sorter: three-stage compare-and-swap pipeline with valid/ready flow control.
// Each stage carries its own sort direction so mixed ascending/descending traffic can overlap.
module sort_unit_vrdy #(
  parameter int p_nbits  = 8,
  parameter bit p_signed = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic               in_desc,
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic [p_nbits-1:0] in2,
  input  logic [p_nbits-1:0] in3,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out0,
  output logic [p_nbits-1:0] out1,
  output logic [p_nbits-1:0] out2,
  output logic [p_nbits-1:0] out3
);

  logic               val_s1_q, val_s2_q, val_s3_q;
  logic               desc_s1_q, desc_s2_q, desc_s3_q;
  logic [p_nbits-1:0] s1_q [4];
  logic [p_nbits-1:0] s2_q [4];
  logic [p_nbits-1:0] s3_q [4];
  logic [p_nbits-1:0] s1_d [4];
  logic [p_nbits-1:0] s2_d [4];
  logic [p_nbits-1:0] s3_d [4];
  logic               stall;

  function automatic logic f_less(input logic [p_nbits-1:0] a, input logic [p_nbits-1:0] b);
    if (p_signed) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  // Upper half of the result goes to the lower index; ties never swap.
  function automatic logic [2*p_nbits-1:0] f_cas(input logic [p_nbits-1:0] a,
                                                 input logic [p_nbits-1:0] b,
                                                 input logic desc);
    logic swap;
    swap = desc ? f_less(a, b) : f_less(b, a);
    return swap ? {b, a} : {a, b};
  endfunction

  assign stall  = val_s3_q && !out_rdy;
  assign in_rdy = !stall;

  always_comb begin
    {s1_d[0], s1_d[1]} = f_cas(in0, in1, in_desc);
    {s1_d[2], s1_d[3]} = f_cas(in2, in3, in_desc);
    {s2_d[0], s2_d[2]} = f_cas(s1_q[0], s1_q[2], desc_s1_q);
    {s2_d[1], s2_d[3]} = f_cas(s1_q[1], s1_q[3], desc_s1_q);
    s3_d[0]            = s2_q[0];
    {s3_d[1], s3_d[2]} = f_cas(s2_q[1], s2_q[2], desc_s2_q);
    s3_d[3]            = s2_q[3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_s1_q <= 1'b0;
      val_s2_q <= 1'b0;
      val_s3_q <= 1'b0;
    end else if (!stall) begin
      val_s1_q <= in_val;
      val_s2_q <= val_s1_q;
      val_s3_q <= val_s2_q;
    end
  end

  // Payload registers need no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (!stall) begin
      desc_s1_q <= in_desc;
      desc_s2_q <= desc_s1_q;
      desc_s3_q <= desc_s2_q;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
    end
  end

  assign out_val = val_s3_q;
  assign out0    = val_s3_q ? s3_q[0] : '0;
  assign out1    = val_s3_q ? s3_q[1] : '0;
  assign out2    = val_s3_q ? s3_q[2] : '0;
  assign out3    = val_s3_q ? s3_q[3] : '0;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown({val_s1_q, val_s2_q, val_s3_q}));
      assert (!$isunknown({in_val, out_rdy}));
    end
  end
`endif

endmodule
